// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its load/clear controller.
//   imem_state_t      : controller states
//   NOP_WORD          : word returned on a faulting fetch
//   DEFAULT_HALT_WORD : default load terminator
//   LANE_B0..LANE_B3  : byte-lane indices; lane 0 carries the MSB (big-endian)
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2
    } imem_state_t;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    localparam int NUM_LANES = 4;
    localparam int LANE_B0   = 0;
    localparam int LANE_B1   = 1;
    localparam int LANE_B2   = 2;
    localparam int LANE_B3   = 3;

endpackage

// File: rtl/imem_byte_bank.sv
// One byte lane of the instruction memory: WORDS x 8 storage indexed by word
// address, one synchronous write port and one registered read port.
//   i_clk, i_rst        : clock, synchronous active-high reset (read register only)
//   i_we/i_waddr/i_wdata: write port
//   i_re/i_raddr        : read request; o_rdata updates only when i_re is high
//   o_rdata             : registered read data, holds between reads
module imem_byte_bank #(
    parameter int WORDS = 64,
    localparam int WA   = $clog2(WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [WA-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_re,
    input  logic [WA-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    // Storage is deliberately not reset: program contents survive i_rst.
    logic [7:0] mem [WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdata <= 8'h00;
        end else if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/imem_loader_ctrl.sv
// Byte-addressed, big-endian instruction memory with integrated load/clear
// controller. Serves registered single-cycle word fetches while idle, accepts
// a byte stream to reprogram itself, and can bulk-clear to zero.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_fetch_en, i_pc             : fetch request and byte address
//   o_instr, o_instr_valid       : fetched word and its one-cycle strobe
//   o_fetch_err                  : last fetch misaligned or out of range
//   i_ld_start, i_ld_valid,
//   i_ld_byte                    : load stream (starts at byte 0)
//   i_clear                      : start bulk clear (wins over i_ld_start)
//   o_busy                       : controller not idle
//   o_ld_done, o_ld_full,
//   o_ld_words                   : load completion pulse, ran-out-of-memory
//                                  flag, complete words written
//
// state | meaning
// IDLE  | fetches serviced, waiting for i_clear / i_ld_start
// LOAD  | writing stream bytes at ptr until HALT word or memory end
// CLEAR | writing one zero word per cycle, word 0 .. last
module imem_loader_ctrl
    import imem_pkg::*;
#(
    parameter int                    DEPTH_BYTES = 256,
    parameter int                    INST_BITS   = 32,
    parameter int                    ADDR_BITS   = 32,
    parameter logic [INST_BITS-1:0]  HALT_WORD   = DEFAULT_HALT_WORD,
    localparam int                   AW          = $clog2(DEPTH_BYTES)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_fetch_en,
    input  logic [ADDR_BITS-1:0] i_pc,
    output logic [INST_BITS-1:0] o_instr,
    output logic                 o_instr_valid,
    output logic                 o_fetch_err,
    input  logic                 i_ld_start,
    input  logic                 i_ld_valid,
    input  logic [7:0]           i_ld_byte,
    input  logic                 i_clear,
    output logic                 o_busy,
    output logic                 o_ld_done,
    output logic                 o_ld_full,
    output logic [AW-2:0]        o_ld_words
);

    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WA    = AW - 2;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_WORD  = AW'(4);
    localparam logic [AW-2:0] WORDS_ONE = (AW-1)'(1);

    if (INST_BITS != 32) begin : g_bad_inst_bits
        $error("imem_loader_ctrl: INST_BITS must be 32");
    end
    if (DEPTH_BYTES < 8 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
        $error("imem_loader_ctrl: DEPTH_BYTES must be a power of two >= 8");
    end
    if (ADDR_BITS < AW) begin : g_bad_addr_bits
        $error("imem_loader_ctrl: ADDR_BITS narrower than memory address");
    end

    imem_state_t     state_q, state_n;
    logic [AW-1:0]   ptr_q, ptr_n;
    logic [23:0]     asm_q, asm_n;
    logic [AW-2:0]   words_q, words_n;
    logic            full_q, full_n;
    logic            done_q, done_n;

    logic [31:0]     ld_word;
    logic [NUM_LANES-1:0] lane_we;
    logic [WA-1:0]   waddr;
    logic [7:0]      wdata;

    // Assembly register keeps only the three previous bytes; the incoming byte
    // completes the word so the HALT compare sees it on the writing edge.
    assign ld_word = {asm_q, i_ld_byte};

    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        asm_n   = asm_q;
        words_n = words_q;
        full_n  = full_q;
        done_n  = 1'b0;
        lane_we = '0;
        waddr   = ptr_q[AW-1:2];
        wdata   = i_ld_byte;

        case (state_q)
            IDLE: begin
                if (i_clear) begin
                    state_n = CLEAR;
                    ptr_n   = '0;
                end else if (i_ld_start) begin
                    state_n = LOAD;
                    ptr_n   = '0;
                    asm_n   = '0;
                    words_n = '0;
                    full_n  = 1'b0;
                end
            end
            LOAD: begin
                if (i_ld_valid) begin
                    lane_we[ptr_q[1:0]] = 1'b1;
                    ptr_n               = ptr_q + PTR_ONE;
                    asm_n               = ld_word[23:0];
                    if (ptr_q[1:0] == 2'd3) begin
                        words_n = words_q + WORDS_ONE;
                        if (ld_word == HALT_WORD) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else if (&ptr_q) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                            full_n  = 1'b1;
                        end
                    end
                end
            end
            CLEAR: begin
                lane_we = '1;
                wdata   = 8'h00;
                ptr_n   = ptr_q + PTR_WORD;
                if (&ptr_q[AW-1:2]) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            asm_q   <= '0;
            words_q <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            asm_q   <= asm_n;
            words_q <= words_n;
            full_q  <= full_n;
            done_q  <= done_n;
        end
    end

    // Fetch path. Only IDLE fetches read the banks, so reads and writes never
    // collide; a fetch on the cycle that accepts a start still sees old data.
    logic           fetch_req;
    logic           fetch_bad;
    logic           fetch_ok;
    logic           err_q;
    logic           valid_q;
    logic [7:0]     rd [NUM_LANES];

    assign fetch_req = (state_q == IDLE) && i_fetch_en;
    assign fetch_bad = (i_pc[1:0] != 2'b00) || ((i_pc >> AW) != '0);
    assign fetch_ok  = fetch_req && !fetch_bad;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= fetch_req;
            if (fetch_req) begin
                err_q <= fetch_bad;
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        imem_byte_bank #(
            .WORDS (WORDS)
        ) u_bank (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_we    (lane_we[l]),
            .i_waddr (waddr),
            .i_wdata (wdata),
            .i_re    (fetch_ok),
            .i_raddr (i_pc[AW-1:2]),
            .o_rdata (rd[l])
        );
    end

    // Bank read registers hold on faulting fetches, so the NOP is forced here.
    assign o_instr       = err_q ? NOP_WORD
                                 : {rd[LANE_B0], rd[LANE_B1], rd[LANE_B2], rd[LANE_B3]};
    assign o_instr_valid = valid_q;
    assign o_fetch_err   = err_q;
    assign o_busy        = (state_q != IDLE);
    assign o_ld_done     = done_q;
    assign o_ld_full     = full_q;
    assign o_ld_words    = words_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
module tb_imem_loader_ctrl;

    localparam int DEPTH = 256;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk;
    logic        i_rst;
    logic        i_fetch_en;
    logic [31:0] i_pc;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        o_fetch_err;
    logic        i_ld_start;
    logic        i_ld_valid;
    logic [7:0]  i_ld_byte;
    logic        i_clear;
    logic        o_busy;
    logic        o_ld_done;
    logic        o_ld_full;
    logic [6:0]  o_ld_words;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference memory: plain byte array, updated from the load/clear rules.
    logic [7:0] mem_m [DEPTH];

    imem_loader_ctrl #(
        .DEPTH_BYTES (DEPTH),
        .INST_BITS   (32),
        .ADDR_BITS   (32),
        .HALT_WORD   (HALT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_fetch_en    (i_fetch_en),
        .i_pc          (i_pc),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .o_fetch_err   (o_fetch_err),
        .i_ld_start    (i_ld_start),
        .i_ld_valid    (i_ld_valid),
        .i_ld_byte     (i_ld_byte),
        .i_clear       (i_clear),
        .o_busy        (o_busy),
        .o_ld_done     (o_ld_done),
        .o_ld_full     (o_ld_full),
        .o_ld_words    (o_ld_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        if (pc[1:0] != 2'b00 || pc >= 32'(DEPTH)) return 32'h0;
        return {mem_m[pc], mem_m[pc+1], mem_m[pc+2], mem_m[pc+3]};
    endfunction

    function automatic logic exp_err(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc >= 32'(DEPTH));
    endfunction

    // Applies a byte stream to the reference memory; reports where the load
    // ends (-1 if the stream runs out first), the full flag and word count.
    task automatic model_load(input logic [7:0] b[$], output int done_at,
                              output bit full, output int words);
        done_at = -1;
        full    = 1'b0;
        words   = 0;
        for (int k = 0; k < b.size() && k < DEPTH; k++) begin
            mem_m[k] = b[k];
            if (k % 4 == 3) begin
                words++;
                if ({mem_m[k-3], mem_m[k-2], mem_m[k-1], mem_m[k]} == HALT) begin
                    done_at = k;
                    break;
                end
                if (k == DEPTH - 1) begin
                    full    = 1'b1;
                    done_at = k;
                    break;
                end
            end
        end
    endtask

    task automatic do_fetch(input logic [31:0] pc, output logic [31:0] instr,
                            output logic v, output logic e);
        i_fetch_en = 1'b1;
        i_pc       = pc;
        tick();
        instr      = o_instr;
        v          = o_instr_valid;
        e          = o_fetch_err;
        i_fetch_en = 1'b0;
    endtask

    // Streams bytes into the DUT, optionally with idle gaps; records every
    // o_ld_done pulse, including any after the stream.
    task automatic run_load(input logic [7:0] b[$], input bit gaps,
                            output bit busy_after_start, output int done_cnt,
                            output int done_at);
        done_cnt   = 0;
        done_at    = -1;
        i_ld_start = 1'b1;
        tick();
        i_ld_start = 1'b0;
        busy_after_start = o_busy;
        if (o_ld_done) done_cnt++;
        for (int i = 0; i < b.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                i_ld_valid = 1'b0;
                tick();
                if (o_ld_done) done_cnt++;
            end
            i_ld_valid = 1'b1;
            i_ld_byte  = b[i];
            tick();
            if (o_ld_done) begin
                done_cnt++;
                done_at = i;
            end
        end
        i_ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_ld_done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            i_fetch_en = 1'($urandom);
            i_pc       = 32'($urandom_range(0, 15)) << 2;
            i_ld_start = 1'($urandom);
            i_ld_valid = 1'($urandom);
            i_ld_byte  = 8'($urandom);
            i_clear    = 1'($urandom);
            tick();
            n_checks++;
            if ({o_instr, o_instr_valid, o_fetch_err, o_busy, o_ld_done, o_ld_full, o_ld_words} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: instr=%h v=%b err=%b busy=%b done=%b full=%b words=%0d, required all 0",
                         o_instr, o_instr_valid, o_fetch_err, o_busy, o_ld_done, o_ld_full, o_ld_words);
            end
        end
        i_fetch_en = 1'b0; i_ld_start = 1'b0; i_ld_valid = 1'b0; i_clear = 1'b0;
        i_rst = 1'b0;
        begin
            logic [31:0] w; logic v, e;
            do_fetch(32'd0, w, v, e);
            n_checks++;
            if (w !== 32'h0 || v !== 1'b1 || e !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_fetch0: instr=%h v=%b err=%b, required 00000000 1 0", w, v, e);
            end
        end
    endtask

    task automatic test_program_load();
        logic [7:0] b[$] = '{8'h3C, 8'h08, 8'h00, 8'h00, 8'h81, 8'h09, 8'h00, 8'h01,
                             8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [31:0] exp_pc [3] = '{32'h3C080000, 32'h81090001, 32'hFFFFFFFF};
        int m_done, m_words, d_cnt, d_at;
        bit m_full, busy0;
        logic [31:0] w; logic v, e;
        model_load(b, m_done, m_full, m_words);
        run_load(b, 1'b0, busy0, d_cnt, d_at);
        n_checks++;
        if (busy0 !== 1'b1) begin
            n_fail++; $display("FAIL prog_busy_start: busy=%b, required 1", busy0);
        end
        n_checks++;
        if (d_cnt != 1 || d_at != m_done) begin
            n_fail++; $display("FAIL prog_done: pulses=%0d at byte %0d, required 1 at %0d", d_cnt, d_at, m_done);
        end
        n_checks++;
        if (o_ld_words !== 7'(m_words) || o_ld_full !== m_full || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL prog_status: words=%0d full=%b busy=%b, required %0d %b 0",
                     o_ld_words, o_ld_full, o_busy, m_words, m_full);
        end
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'(i * 4), w, v, e);
            n_checks++;
            if (w !== exp_pc[i] || v !== 1'b1 || e !== 1'b0) begin
                n_fail++;
                $display("FAIL prog_fetch pc=%0d: instr=%h v=%b err=%b, required %h 1 0", i * 4, w, v, e, exp_pc[i]);
            end
        end
    endtask

    task automatic test_fetch_errors();
        logic [31:0] pcs [4] = '{32'd2, 32'd256, 32'd4, 32'd3};
        logic [31:0] w; logic v, e;
        logic [31:0] last_exp;
        for (int i = 0; i < 4; i++) begin
            do_fetch(pcs[i], w, v, e);
            n_checks++;
            if (w !== exp_word(pcs[i]) || v !== 1'b1 || e !== exp_err(pcs[i])) begin
                n_fail++;
                $display("FAIL fetch_err pc=%0d: instr=%h v=%b err=%b, required %h 1 %b",
                         pcs[i], w, v, e, exp_word(pcs[i]), exp_err(pcs[i]));
            end
        end
        do_fetch(32'd8, w, v, e);
        last_exp = exp_word(32'd8);
        i_pc = 32'd2;
        tick();
        n_checks++;
        if (o_instr_valid !== 1'b0 || o_instr !== last_exp || o_fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_hold: instr=%h v=%b err=%b, required %h 0 0",
                     o_instr, o_instr_valid, o_fetch_err, last_exp);
        end
    endtask

    task automatic test_load_full();
        logic [7:0] b[$];
        int m_done, m_words, d_cnt, d_at;
        bit m_full, busy0;
        logic [31:0] w; logic v, e;
        for (int k = 0; k < DEPTH; k++)
            b.push_back((k % 4 == 0) ? 8'($urandom_range(0, 254)) : 8'($urandom));
        model_load(b, m_done, m_full, m_words);
        for (int k = 0; k < 4; k++) b.push_back(8'hFF);
        run_load(b, 1'b1, busy0, d_cnt, d_at);
        n_checks++;
        if (d_cnt != 1 || d_at != 255 || m_done != 255) begin
            n_fail++; $display("FAIL full_done: pulses=%0d at byte %0d, required 1 at 255", d_cnt, d_at);
        end
        n_checks++;
        if (o_ld_full !== 1'b1 || o_ld_words !== 7'(m_words) || m_words != 64 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_status: full=%b words=%0d busy=%b, required 1 64 0", o_ld_full, o_ld_words, o_busy);
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] pc;
            pc = (i < 2) ? 32'(i * 252) : 32'($urandom_range(0, 63) * 4);
            do_fetch(pc, w, v, e);
            n_checks++;
            if (w !== exp_word(pc) || e !== 1'b0) begin
                n_fail++; $display("FAIL full_fetch pc=%0d: instr=%h err=%b, required %h 0", pc, w, e, exp_word(pc));
            end
        end
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        logic [31:0] held;
        logic [31:0] w; logic v, e;
        held       = exp_word(32'd4);
        i_clear    = 1'b1;
        i_fetch_en = 1'b1;
        i_pc       = 32'd4;
        tick();
        i_clear = 1'b0;
        n_checks++;
        if (o_instr !== held || o_instr_valid !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_same_cycle_fetch: instr=%h v=%b busy=%b, required %h 1 1", o_instr, o_instr_valid, o_busy, held);
        end
        if (o_busy) busy_cnt = 1;
        for (int c = 0; c < 200 && o_busy; c++) begin
            i_pc = 32'($urandom_range(0, 63)) << 2;
            tick();
            if (o_busy) begin
                busy_cnt++;
                n_checks++;
                if (o_instr_valid !== 1'b0 || o_instr !== held) begin
                    n_fail++;
                    $display("FAIL clear_fetch_blocked: instr=%h v=%b, required %h 0", o_instr, o_instr_valid, held);
                end
            end
        end
        i_fetch_en = 1'b0;
        for (int k = 0; k < DEPTH; k++) mem_m[k] = 8'h00;
        n_checks++;
        if (busy_cnt != DEPTH / 4 || o_ld_done !== 1'b0) begin
            n_fail++; $display("FAIL clear_busy_cycles: busy=%0d cycles done=%b, required 64 0", busy_cnt, o_ld_done);
        end
        do_fetch(32'd4, w, v, e);
        n_checks++;
        if (w !== 32'h0 || v !== 1'b1 || e !== 1'b0) begin
            n_fail++; $display("FAIL clear_fetch4: instr=%h v=%b err=%b, required 00000000 1 0", w, v, e);
        end
    endtask

    task automatic test_clear_priority();
        logic [7:0] b[$] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        int m_done, m_words, d_cnt, d_at, busy_cnt;
        bit m_full, busy0, saw_done;
        logic [31:0] w; logic v, e;
        model_load(b, m_done, m_full, m_words);
        run_load(b, 1'b0, busy0, d_cnt, d_at);
        i_clear    = 1'b1;
        i_ld_start = 1'b1;
        tick();
        i_clear  = 1'b0;
        busy_cnt = o_busy ? 1 : 0;
        saw_done = o_ld_done;
        for (int c = 0; c < 200 && o_busy; c++) begin
            i_ld_valid = 1'b1;
            i_ld_byte  = 8'($urandom_range(1, 255));
            tick();
            if (o_busy) busy_cnt++;
            if (o_ld_done) saw_done = 1'b1;
        end
        i_ld_valid = 1'b0;
        i_ld_start = 1'b0;
        tick();
        for (int k = 0; k < DEPTH; k++) mem_m[k] = 8'h00;
        n_checks++;
        if (busy_cnt != DEPTH / 4 || saw_done || o_ld_words !== 7'(m_words) || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_priority: busy=%0d done=%b words=%0d, required 64 0 %0d", busy_cnt, saw_done, o_ld_words, m_words);
        end
        do_fetch(32'd0, w, v, e);
        n_checks++;
        if (w !== exp_word(32'd0)) begin
            n_fail++; $display("FAIL clear_priority_fetch0: instr=%h, required %h", w, exp_word(32'd0));
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] b[$] = '{8'h3C, 8'h08, 8'h00, 8'h00, 8'h81, 8'h09};
        int m_done, m_words;
        bit m_full, saw_done;
        logic [31:0] w; logic v, e;
        model_load(b, m_done, m_full, m_words);
        i_ld_start = 1'b1;
        tick();
        i_ld_start = 1'b0;
        saw_done   = 1'b0;
        for (int i = 0; i < b.size(); i++) begin
            i_ld_valid = 1'b1;
            i_ld_byte  = b[i];
            tick();
            if (o_ld_done) saw_done = 1'b1;
        end
        i_ld_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        if (o_ld_done) saw_done = 1'b1;
        n_checks++;
        if (o_busy !== 1'b0 || o_ld_words !== 7'd0 || saw_done) begin
            n_fail++;
            $display("FAIL midload_reset: busy=%b words=%0d done=%b, required 0 0 0", o_busy, o_ld_words, saw_done);
        end
        i_ld_valid = 1'b1;
        i_ld_byte  = 8'hAA;
        tick();
        i_ld_valid = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_ld_done !== 1'b0) begin
            n_fail++; $display("FAIL midload_ignore_valid: busy=%b done=%b, required 0 0", o_busy, o_ld_done);
        end
        for (int i = 0; i < 2; i++) begin
            logic [31:0] pc = 32'(i * 4);
            do_fetch(pc, w, v, e);
            n_checks++;
            if (w !== exp_word(pc) || (i == 0 && w !== 32'h3C080000)) begin
                n_fail++; $display("FAIL midload_fetch pc=%0d: instr=%h, required %h", pc, w, exp_word(pc));
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] b[$];
            int nw, m_done, m_words, d_cnt, d_at;
            bit m_full, busy0;
            logic [31:0] w; logic v, e;
            nw = $urandom_range(1, 30);
            for (int k = 0; k < nw * 4; k++) b.push_back(8'($urandom));
            for (int k = 0; k < 4; k++) b.push_back(8'hFF);
            model_load(b, m_done, m_full, m_words);
            run_load(b, 1'b1, busy0, d_cnt, d_at);
            n_checks++;
            if (d_cnt != 1 || d_at != m_done || o_ld_words !== 7'(m_words) || o_ld_full !== m_full) begin
                n_fail++;
                $display("FAIL rand_load it=%0d: done=%0d@%0d words=%0d full=%b, required 1@%0d %0d %b",
                         it, d_cnt, d_at, o_ld_words, o_ld_full, m_done, m_words, m_full);
            end
            for (int f = 0; f < 12; f++) begin
                logic [31:0] pc;
                pc = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 300))
                                                 : 32'($urandom_range(0, 63)) << 2;
                do_fetch(pc, w, v, e);
                n_checks++;
                if (w !== exp_word(pc) || v !== 1'b1 || e !== exp_err(pc)) begin
                    n_fail++;
                    $display("FAIL rand_fetch pc=%0d: instr=%h v=%b err=%b, required %h 1 %b",
                             pc, w, v, e, exp_word(pc), exp_err(pc));
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mem_m[k] = 8'h00;
        i_rst = 1'b1; i_fetch_en = 1'b0; i_pc = '0;
        i_ld_start = 1'b0; i_ld_valid = 1'b0; i_ld_byte = '0; i_clear = 1'b0;
        test_reset();
        test_program_load();
        test_fetch_errors();
        test_load_full();
        test_clear();
        test_clear_priority();
        test_reset_midload();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
